ann_layer_engine: RTL and testbench

//  Parametrised fully-connected neural layer: N_OUT neurons, each a signed fixed-point dot product of N_IN inputs plus a bias, then a selectable activation.

---
 rtl/ann_layer_engine_pkg.sv | 27 ++
 rtl/ann_layer_engine_act_unit.sv | 44 ++++
 rtl/ann_layer_engine.sv | 132 +++++++++++++
 tb/tb_ann_layer_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_layer_engine_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
package ann_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_HSIG   = 2'd2
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2
    } state_e;

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int unsigned dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/ann_layer_engine_act_unit.sv
// Per-neuron output stage: drops fraction bits, saturates to DW and applies the activation.
module ann_act_unit
    import ann_pkg::*;
#(
    parameter int DW       = 10,
    parameter int FRAC     = 6,
    parameter int ACT_MODE = 2,
    parameter int ACC_W    = 25
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [DW-1:0]    y_o,
    output logic                    sat_o
);

    localparam logic signed [DW:0] HALF = (DW+1)'(2**(FRAC-1));
    localparam logic signed [DW:0] ONE  = (DW+1)'(2**FRAC);

    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      wide;
    logic signed [63:0]      clipped;
    logic signed [DW-1:0]    pre;
    logic signed [DW:0]      hs;

    assign shifted = acc_i >>> FRAC;
    assign wide    = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
    assign clipped = sat_dw(wide, DW);
    assign sat_o   = (clipped != wide);
    assign pre     = DW'(clipped);

    always_comb begin
        hs  = ((DW+1)'(pre) >>> 2) + HALF;
        y_o = pre;
        case (act_mode_e'(ACT_MODE))
            ACT_RELU: y_o = pre[DW-1] ? '0 : pre;
            ACT_HSIG: begin
                if (hs < 0)        y_o = '0;
                else if (hs > ONE) y_o = DW'(ONE);
                else               y_o = DW'(hs);
            end
            default:  y_o = pre;
        endcase
    end

endmodule

// File: rtl/ann_layer_engine.sv
// Fully-connected layer: N_OUT neurons accumulate one input column per cycle, then activate.
// state | meaning
// IDLE  | waiting for start; weight writes accepted
// MAC   | one multiply-accumulate per neuron for input k
// ACT   | register activated outputs and pulse done
module ann_layer_engine
    import ann_pkg::*;
#(
    parameter int DW       = 10,
    parameter int FRAC     = 6,
    parameter int N_IN     = 30,
    parameter int N_OUT    = 5,
    parameter int ACT_MODE = 2,
    localparam int AW      = $clog2(N_OUT*(N_IN+1)),
    localparam int ACC_W   = 2*DW + $clog2(N_IN+1)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wr_en_i,
    input  logic [AW-1:0]                wr_addr_i,
    input  logic [DW-1:0]                wr_data_i,
    input  logic                         start_i,
    input  logic [N_IN-1:0][DW-1:0]      in_vec_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [N_OUT-1:0][DW-1:0]     out_vec_o,
    output logic                         sat_flag_o
);

    localparam int N_W = N_OUT*(N_IN+1);
    localparam int KW  = $clog2(N_IN+1);
    localparam int B0  = N_OUT*N_IN;

    state_e                      state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [DW-1:0]               w_q [N_W];
    logic [N_IN-1:0][DW-1:0]     in_q;
    logic signed [ACC_W-1:0]     acc_q [N_OUT];
    logic signed [ACC_W-1:0]     acc_d [N_OUT];
    logic signed [2*DW-1:0]      prod  [N_OUT];
    logic [N_OUT-1:0][DW-1:0]    bias_v;
    logic [N_OUT-1:0][DW-1:0]    out_q, act_y;
    logic [N_OUT-1:0]            act_sat;
    logic                        sat_q, done_q, wr_ok, start_ok;

    assign wr_ok    = wr_en_i && (state_q == IDLE) && (32'(wr_addr_i) < N_W);
    assign start_ok = start_i && (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = MAC;
            MAC:     if (k_q == KW'(N_IN-1)) state_d = ACT;
            ACT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        done_o     = done_q;
        out_vec_o  = out_q;
        sat_flag_o = sat_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int a = 0; a < N_W; a++) w_q[a] <= '0;
        end else if (wr_ok) begin
            w_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A bias written on the start edge is forwarded so the new value seeds the accumulator.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            bias_v[j] = (wr_ok && (wr_addr_i == AW'(B0 + j))) ? wr_data_i : w_q[AW'(B0 + j)];
            prod[j]   = (2*DW)'($signed(in_q[k_q])) * (2*DW)'($signed(w_q[AW'(j*N_IN) + AW'(k_q)]));
        end
    end

    always_comb begin
        k_d   = k_q;
        acc_d = acc_q;
        if (start_ok) begin
            k_d = '0;
            for (int j = 0; j < N_OUT; j++) acc_d[j] = ACC_W'($signed(bias_v[j])) <<< FRAC;
        end else if (state_q == MAC) begin
            k_d = k_q + 1'b1;
            for (int j = 0; j < N_OUT; j++) acc_d[j] = acc_q[j] + ACC_W'(prod[j]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            k_q    <= '0;
            in_q   <= '0;
            acc_q  <= '{default: '0};
            out_q  <= '0;
            sat_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            acc_q  <= acc_d;
            done_q <= (state_q == ACT);
            if (start_ok) in_q <= in_vec_i;
            if (state_q == ACT) begin
                out_q <= act_y;
                sat_q <= |act_sat;
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_act
        ann_act_unit #(
            .DW       (DW),
            .FRAC     (FRAC),
            .ACT_MODE (ACT_MODE),
            .ACC_W    (ACC_W)
        ) u_act (
            .acc_i (acc_q[j]),
            .y_o   (act_y[j]),
            .sat_o (act_sat[j])
        );
    end

endmodule

// File: tb/tb_ann_layer_engine.sv
// Scoreboard bench: three engines (linear, ReLU, hard sigmoid) share all stimulus.
module tb_ann_layer_engine;

    localparam int DW    = 10;
    localparam int N_IN  = 30;
    localparam int N_OUT = 5;
    localparam int AW    = $clog2(N_OUT*(N_IN+1));
    localparam int PMAX  = 2**(DW-1) - 1;
    localparam int PMIN  = -(2**(DW-1));
    localparam int LAT   = N_IN + 2;

    typedef struct {
        logic [N_OUT-1:0][DW-1:0] vec;
        logic                     sat;
        int                       cyc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      wr_en = 1'b0;
    logic [AW-1:0]             wr_addr = '0;
    logic [DW-1:0]             wr_data = '0;
    logic                      start = 1'b0;
    logic [N_IN-1:0][DW-1:0]   in_vec = '0;
    logic [2:0]                busy, done, sat;
    logic [N_OUT-1:0][DW-1:0]  out_vec [3];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q [3][$];
    exp_t mon_e;
    int   t4_pre  [N_OUT] = '{0, 60, -200, 400, -4};
    int   pre7    [N_OUT] = '{7, 60, -200, 400, -4};
    int   all60   [N_OUT] = '{60, 60, 60, 60, 60};
    int   all1920 [N_OUT] = '{1920, 1920, 1920, 1920, 1920};
    int   allm5   [N_OUT] = '{-5, -5, -5, -5, -5};
    int   zeros   [N_OUT] = '{0, 0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        ann_layer_engine #(.ACT_MODE(m)) u_dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .start_i    (start),
            .in_vec_i   (in_vec),
            .busy_o     (busy[m]),
            .done_o     (done[m]),
            .out_vec_o  (out_vec[m]),
            .sat_flag_o (sat[m])
        );
    end

    function automatic int act_ref(input int pre, input int mode);
        int p, h;
        p = (pre > PMAX) ? PMAX : ((pre < PMIN) ? PMIN : pre);
        case (mode)
            0:       return p;
            1:       return (p < 0) ? 0 : p;
            default: begin
                h = (p >>> 2) + 32;
                return (h < 0) ? 0 : ((h > 64) ? 64 : h);
            end
        endcase
    endfunction

    task automatic push_exp(input int pre [N_OUT], input int at_cyc);
        exp_t e;
        for (int m = 0; m < 3; m++) begin
            e.sat = 1'b0;
            e.cyc = at_cyc;
            for (int j = 0; j < N_OUT; j++) begin
                e.vec[j] = DW'(act_ref(pre[j], m));
                if (pre[j] > PMAX || pre[j] < PMIN) e.sat = 1'b1;
            end
            exp_q[m].push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h", name, m, act, req);
        end
    endtask

    task automatic wr(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_uniform(input int w, input int b);
        for (int a = 0; a < N_OUT*N_IN; a++) wr(a, w);
        for (int j = 0; j < N_OUT; j++) wr(N_OUT*N_IN + j, b);
    endtask

    task automatic load_t4();
        wr(1*N_IN + 5, 60);
        wr(2*N_IN, -100);
        wr(N_OUT*N_IN + 2, -100);
        wr(3*N_IN, 200);
        wr(N_OUT*N_IN + 3, 200);
        wr(4*N_IN, -3);
        wr(4*N_IN + 29, -1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 2*LAT) begin
            tick();
            t++;
        end
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", 2*LAT);
            for (int m = 0; m < 3; m++) exp_q[m].delete();
        end
    endtask

    task automatic run(input int in_val, input int pre [N_OUT]);
        push_exp(pre, cyc + LAT);
        in_vec = {N_IN{DW'(in_val)}};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_in_mac", 0, 64'(busy[0]), 64'd1);
        wait_done();
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (done[m]) begin
                n_tests++;
                if (exp_q[m].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done dut=%0d actual=1 required=0 cyc=%0d", m, cyc);
                end else begin
                    mon_e = exp_q[m].pop_front();
                    if (cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL done_latency dut=%0d actual=%0d required=%0d", m, cyc, mon_e.cyc);
                    end
                    n_tests++;
                    if (out_vec[m] !== mon_e.vec) begin
                        n_fail++;
                        $display("FAIL out_vec dut=%0d actual=%0h required=%0h", m, out_vec[m], mon_e.vec);
                    end
                    n_tests++;
                    if (sat[m] !== mon_e.sat) begin
                        n_fail++;
                        $display("FAIL sat_flag dut=%0d actual=%0b required=%0b", m, sat[m], mon_e.sat);
                    end
                    n_tests++;
                    if (busy[m] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL done_with_busy dut=%0d actual=%0b required=0", m, busy[m]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk("rst_busy", m, 64'(busy[m]), 64'd0);
            chk("rst_done", m, 64'(done[m]), 64'd0);
            chk("rst_sat",  m, 64'(sat[m]),  64'd0);
            chk("rst_out",  m, 64'(out_vec[m]), 64'd0);
        end
        tick();

        // Uniform weights 1.0, small and saturating inputs, then bias only
        load_uniform(64, 0);
        run(2, all60);
        run(64, all1920);
        for (int j = 0; j < N_OUT; j++) wr(N_OUT*N_IN + j, -5);
        run(0, allm5);

        // Mixed per-neuron values from a clean weight store
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        load_t4();
        run(64, t4_pre);

        // start and weight write while busy are ignored
        push_exp(t4_pre, cyc + LAT);
        in_vec = {N_IN{DW'(64)}};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (10) tick();
        chk("busy_k10", 0, 64'(busy[0]), 64'd1);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = DW'(100);
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        wait_done();
        repeat (LAT + 8) tick();
        run(64, t4_pre);

        // Write and start on the same idle edge; input changes after start
        push_exp(pre7, cyc + LAT);
        in_vec  = {N_IN{DW'(64)}};
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = DW'(7);
        tick();
        start  = 1'b0;
        wr_en  = 1'b0;
        in_vec = '0;
        wait_done();

        // Reset mid-computation
        in_vec = {N_IN{DW'(64)}};
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk("midrst_busy", m, 64'(busy[m]), 64'd0);
            chk("midrst_done", m, 64'(done[m]), 64'd0);
            chk("midrst_out",  m, 64'(out_vec[m]), 64'd0);
            chk("midrst_sat",  m, 64'(sat[m]), 64'd0);
        end
        tick();
        rst_n = 1'b1;
        repeat (LAT + 8) tick();
        run(64, zeros);
        load_t4();
        run(64, t4_pre);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
